imu_rx: RTL and testbench
=========================

# imu_rx

Receiving end of the synthetic IMU sample stream. Accepts `imu_data`/`valid` beats from the IMU sequencer (no backpressure on the source side) and buffers them in a small FIFO. It tags each sample with its position in a SEQ_LEN-sample frame, accumulates a per-frame sum, and re-presents samples downstream on a valid/ready interface. Sits between the IMU source and the fusion datapath.

## Interface
- `DATA_WIDTH`, 16, sample width (unsigned)
- `SEQ_LEN`, 16, samples per frame; ≥2, power of two
- `FIFO_DEPTH`, 8, sample buffer entries; ≥2, power of two
- `SUM_W`, DATA_WIDTH+$clog2(SEQ_LEN), frame sum width (derived, not overridden)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `enable`  in  1  receive enable
- `imu_data`  in  DATA_WIDTH  incoming sample
- `valid`  in  1  incoming sample valid; one sample per cycle when high
- `out_data`  out  DATA_WIDTH  FIFO head sample
- `out_last`  out  1  head sample is last of its frame
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  downstream accepts head
- `frame_sum`  out  SUM_W  sum of the completed frame
- `sum_valid`  out  1  one-cycle pulse, frame_sum/frame_err valid
- `frame_err`  out  1  completed frame had ≥1 dropped sample
- `overflow`  out  1  sticky: any sample dropped since reset
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- Input beat = `valid && enable`. Beats with `enable` low are ignored.
- Frame FSM has two states:
  - IDLE (idx=0, acc=0, err=0): a beat stores the sample, sets acc=imu_data, idx=1, moves to RECV.
  - RECV: each beat sets acc+=imu_data and idx+=1. On the beat where idx==SEQ_LEN-1, it pulses sum_valid with frame_sum=acc+imu_data and frame_err=err|drop_this_beat, tags the entry last=1, and returns to IDLE.
- `enable` falling in RECV aborts the partial frame: back to IDLE, no sum_valid, buffered samples stay in the FIFO.
- Drop: a beat arriving when the FIFO is full with no pop that cycle is not written. On a drop:
  - overflow is set (sticky).
  - err is set for the current frame.
  - idx and acc still advance, with acc including the dropped value, so frame alignment is preserved.
- Full with a simultaneous pop: the write is accepted, no drop.
- FIFO entry = {last, data}. Output is first-word-fall-through: out_valid = !empty, and pop = out_valid && out_ready.
- Pop on empty is impossible (out_valid low). Push and pop in the same cycle leave the level unchanged.
- Pointers wrap modulo FIFO_DEPTH; level is tracked separately to distinguish full from empty.
- Arithmetic is unsigned. acc is SUM_W wide and cannot overflow.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, sum_valid=0, frame_sum=0, frame_err=0, overflow=0, fifo_level=0. FSM resets to IDLE, pointers to 0.
- `rst` high mid-frame clears everything on that edge, and buffered samples are lost.
- Latency: beat at edge N → out_valid=1 and out_data valid after edge N, visible cycle N+1.
- sum_valid is registered: the last beat at edge N → pulse high for exactly the cycle after edge N. frame_sum holds until the next pulse.
- A back-to-back frame is allowed: the first beat of the next frame may arrive the cycle after the last beat of the previous one.
- out_data and out_last are stable while out_valid && !out_ready.

## Structure
- Shared package `imu_pkg` holds:
  - typedef `imu_entry_t` {last, data}
  - the frame FSM state enum (IDLE, RECV)
  - function `sum_width(DATA_WIDTH, SEQ_LEN)`
- Sub-module `imu_rx_fifo`: synchronous FWFT FIFO parameterised by entry width and depth, with push/pop/full/empty/level.
- Frame FSM, accumulator and drop logic live in `imu_rx`.

## Test plan
- Nominal frame: enable=1, 16 consecutive beats of 100+2i, out_ready=1 → 16 samples out in order, out_last only on 116th... on the sample 130. Then sum_valid one cycle with frame_sum=1840, frame_err=0, overflow=0.
- Backpressure overflow: out_ready=0, 12 beats with FIFO_DEPTH=8 → fifo_level saturates at 8 and beats 9–12 are dropped. overflow=1. No sum_valid until 16 beats; that frame then reports frame_err=1 with sum including all 16 values.
- Full plus pop: FIFO at 8, one beat together with out_ready=1 → no drop, level stays 8, overflow stays 0.
- Abort: 5 beats, then enable=0 for 3 cycles, then 16 beats → no sum_valid for the partial frame. One sum_valid after the 16 fresh beats, with sum over only those beats. The 5 early samples still drain first.
- Back-to-back frames: 32 continuous beats → sum_valid pulses exactly twice, 16 cycles apart, out_last on samples 16 and 32.
- Reset mid-frame: rst for 1 cycle after beat 7 with the FIFO non-empty → all outputs at reset values next cycle. The next 16 beats form a clean frame (frame_err=0).

Source files
------------

// File: rtl/imu_pkg.sv
// Shared types and helpers for the IMU receive path.
package imu_pkg;

    // Default sample width of the IMU stream.
    localparam int IMU_DATA_WIDTH = 16;

    // One FIFO entry: frame-last tag above the sample payload.
    typedef struct packed {
        logic                      last;
        logic [IMU_DATA_WIDTH-1:0] data;
    } imu_entry_t;

    // Frame tracking FSM states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } frame_state_e;

    // Width needed to sum seq_len unsigned samples of data_width bits without overflow.
    function automatic int sum_width(input int data_width, input int seq_len);
        return data_width + $clog2(seq_len);
    endfunction

endpackage

// File: rtl/imu_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level.
// A push while full is accepted only when a pop happens in the same cycle.
module imu_rx_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (level_q == {LVL_W{1'b0}});
    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Next pointer and level values; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/imu_rx.sv
// IMU sample receiver: buffers incoming samples, tags frame boundaries,
// accumulates per-frame sums and flags frames that lost samples.
module imu_rx
    import imu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int SUM_W     = sum_width(DATA_WIDTH, SEQ_LEN),
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] imu_data,
    input  logic                  valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_W-1:0]      frame_sum,
    output logic                  sum_valid,
    output logic                  frame_err,
    output logic                  overflow,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int IDX_W   = $clog2(SEQ_LEN);
    localparam int ENTRY_W = DATA_WIDTH + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);

    frame_state_e     state_q;
    frame_state_e     state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] acc_d;
    logic             err_q;
    logic             err_d;
    logic             sum_valid_q;
    logic             sum_valid_d;
    logic [SUM_W-1:0] frame_sum_q;
    logic [SUM_W-1:0] frame_sum_d;
    logic             frame_err_q;
    logic             frame_err_d;
    logic             overflow_q;
    logic             overflow_d;

    logic               beat_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               full_s;
    logic               empty_s;
    logic               last_s;
    logic [SUM_W-1:0]   acc_sum_s;
    logic [ENTRY_W-1:0] wdata_s;
    logic [ENTRY_W-1:0] rdata_s;

    // Entry layout matches imu_entry_t: {last, data}.
    assign beat_s    = valid && enable;
    assign pop_s     = out_valid && out_ready;
    assign drop_s    = beat_s && full_s && !pop_s;
    assign push_s    = beat_s && !drop_s;
    assign acc_sum_s = acc_q + SUM_W'(imu_data);
    assign wdata_s   = {last_s, imu_data};

    imu_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (wdata_s),
        .rdata_o (rdata_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (fifo_level)
    );

    // Head of FIFO is forced to zero while empty so stale storage never leaks out.
    assign out_valid = !empty_s;
    assign out_data  = empty_s ? {DATA_WIDTH{1'b0}} : rdata_s[DATA_WIDTH-1:0];
    assign out_last  = empty_s ? 1'b0 : rdata_s[DATA_WIDTH];
    assign frame_sum = frame_sum_q;
    assign sum_valid = sum_valid_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    // Frame FSM: position tracking, accumulation, end-of-frame reporting and abort.
    // Dropped samples still advance idx/acc so frame alignment is kept.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        err_d       = err_q;
        sum_valid_d = 1'b0;
        frame_sum_d = frame_sum_q;
        frame_err_d = frame_err_q;
        last_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat_s) begin
                    acc_d   = SUM_W'(imu_data);
                    idx_d   = IDX_W'(1);
                    err_d   = drop_s;
                    state_d = ST_RECV;
                end else begin
                    acc_d   = {SUM_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (!enable) begin
                    // Partial frame abandoned; buffered samples stay queued.
                    acc_d   = {SUM_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (beat_s) begin
                    if (idx_q == IDX_LAST) begin
                        sum_valid_d = 1'b1;
                        frame_sum_d = acc_sum_s;
                        frame_err_d = err_q | drop_s;
                        last_s      = 1'b1;
                        acc_d       = {SUM_W{1'b0}};
                        idx_d       = {IDX_W{1'b0}};
                        err_d       = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        acc_d   = acc_sum_s;
                        idx_d   = idx_q + IDX_W'(1);
                        err_d   = err_q | drop_s;
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            default: begin
                acc_d   = {SUM_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overflow flag.
    always_comb begin
        overflow_d = overflow_q | drop_s;
    end

    // Frame state and reporting registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            acc_q       <= {SUM_W{1'b0}};
            err_q       <= 1'b0;
            sum_valid_q <= 1'b0;
            frame_sum_q <= {SUM_W{1'b0}};
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            sum_valid_q <= sum_valid_d;
            frame_sum_q <= frame_sum_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_imu_rx.sv
// Directed self-checking bench for imu_rx (default parameters).
module tb_imu_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] imu_data;
    logic        valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] frame_sum;
    logic        sum_valid;
    logic        frame_err;
    logic        overflow;
    logic [3:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    imu_rx dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .imu_data   (imu_data),
        .valid      (valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_sum  (frame_sum),
        .sum_valid  (sum_valid),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        vld;
        logic [15:0] d;
        logic        rdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_last;
        logic [3:0]  e_lvl;
        logic        e_sv;
        logic        e_ovf;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic vld, input logic [15:0] d, input logic rdy);
        enable    = en;
        valid     = vld;
        imu_data  = d;
        out_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
        chk({tag, "_out_data"},   {16'd0, out_data},   32'd0);
        chk({tag, "_out_last"},   {31'd0, out_last},   32'd0);
        chk({tag, "_sum_valid"},  {31'd0, sum_valid},  32'd0);
        chk({tag, "_frame_sum"},  {12'd0, frame_sum},  32'd0);
        chk({tag, "_frame_err"},  {31'd0, frame_err},  32'd0);
        chk({tag, "_overflow"},   {31'd0, overflow},   32'd0);
        chk({tag, "_fifo_level"}, {28'd0, fifo_level}, 32'd0);
    endtask

    initial begin
        int pulses;
        int first_pulse;
        int second_pulse;

        rst = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 1'b0);

        // ---------------- reset state ----------------
        do_reset();
        chk_reset_state("reset");

        // ---------------- table-driven short sequence ----------------
        //           en    vld   d       rdy   e_ov  e_od    e_last e_lvl e_sv  e_ovf
        vt[0] = '{1'b1, 1'b1, 16'd5, 1'b0, 1'b1, 16'd5, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 16'd6, 1'b0, 1'b1, 16'd5, 1'b0, 4'd2, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b1, 16'd7, 1'b1, 1'b1, 16'd6, 1'b0, 4'd2, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 16'd7, 1'b0, 4'd1, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 16'd9, 1'b1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 16'd3, 1'b0, 4'd1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].en, vt[i].vld, vt[i].d, vt[i].rdy);
            step();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].e_ov});
            chk($sformatf("vec%0d_out_data", i), {16'd0, out_data}, {16'd0, vt[i].e_od});
            chk($sformatf("vec%0d_out_last", i), {31'd0, out_last}, {31'd0, vt[i].e_last});
            chk($sformatf("vec%0d_level", i), {28'd0, fifo_level}, {28'd0, vt[i].e_lvl});
            chk($sformatf("vec%0d_sum_valid", i), {31'd0, sum_valid}, {31'd0, vt[i].e_sv});
            chk($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vt[i].e_ovf});
        end

        // ---------------- nominal frame: 100,102,...,130 ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 16'(100 + 2 * i), 1'b1);
            step();
            chk("nom_out_valid", {31'd0, out_valid}, 32'd1);
            chk("nom_out_data", {16'd0, out_data}, 32'(100 + 2 * i));
            chk("nom_out_last", {31'd0, out_last}, (i == 15) ? 32'd1 : 32'd0);
            chk("nom_level", {28'd0, fifo_level}, 32'd1);
            chk("nom_sum_valid", {31'd0, sum_valid}, (i == 15) ? 32'd1 : 32'd0);
        end
        chk("nom_frame_sum", {12'd0, frame_sum}, 32'd1840);
        chk("nom_frame_err", {31'd0, frame_err}, 32'd0);
        chk("nom_overflow", {31'd0, overflow}, 32'd0);
        drive(1'b1, 1'b0, 16'd0, 1'b1);
        step();
        chk("nom_pulse_end", {31'd0, sum_valid}, 32'd0);
        chk("nom_sum_hold", {12'd0, frame_sum}, 32'd1840);
        chk("nom_drained", {28'd0, fifo_level}, 32'd0);

        // ---------------- backpressure overflow: 1..16, out_ready low ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 16'(i + 1), 1'b0);
            step();
            chk("bp_level", {28'd0, fifo_level}, (i < 8) ? 32'(i + 1) : 32'd8);
            chk("bp_overflow", {31'd0, overflow}, (i >= 8) ? 32'd1 : 32'd0);
            chk("bp_sum_valid", {31'd0, sum_valid}, (i == 15) ? 32'd1 : 32'd0);
        end
        chk("bp_frame_sum", {12'd0, frame_sum}, 32'd136);
        chk("bp_frame_err", {31'd0, frame_err}, 32'd1);
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, 1'b0, 16'd0, 1'b1);
            chk("bp_drain_data", {16'd0, out_data}, 32'(j + 1));
            chk("bp_drain_last", {31'd0, out_last}, 32'd0);
            step();
        end
        chk("bp_drain_level", {28'd0, fifo_level}, 32'd0);
        chk("bp_overflow_sticky", {31'd0, overflow}, 32'd1);

        // ---------------- reset mid-frame (follows dirty state above) ----------------
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 16'(40 + i), 1'b0);
            step();
        end
        chk("rmf_pre_level", {28'd0, fifo_level}, 32'd7);
        rst = 1'b1;
        drive(1'b1, 1'b0, 16'd0, 1'b0);
        step();
        chk_reset_state("rmf");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 16'(1000 + i), 1'b1);
            step();
            chk("rmf_sum_valid", {31'd0, sum_valid}, (i == 15) ? 32'd1 : 32'd0);
        end
        chk("rmf_frame_sum", {12'd0, frame_sum}, 32'd16120);
        chk("rmf_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rmf_overflow", {31'd0, overflow}, 32'd0);

        // ---------------- full plus pop ----------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 16'(10 + i), 1'b0);
            step();
        end
        chk("fp_full_level", {28'd0, fifo_level}, 32'd8);
        drive(1'b1, 1'b1, 16'd50, 1'b1);
        step();
        chk("fp_level", {28'd0, fifo_level}, 32'd8);
        chk("fp_overflow", {31'd0, overflow}, 32'd0);
        chk("fp_head", {16'd0, out_data}, 32'd11);
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, 1'b0, 16'd0, 1'b1);
            chk("fp_drain_data", {16'd0, out_data}, (j < 7) ? 32'(11 + j) : 32'd50);
            step();
        end
        chk("fp_drain_level", {28'd0, fifo_level}, 32'd0);

        // ---------------- abort: 5 beats, enable low 3 cycles, 16 fresh beats ----------------
        do_reset();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 16'(i + 1), 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'd0, 1'b0);
            step();
            chk("ab_gap_sum_valid", {31'd0, sum_valid}, 32'd0);
            chk("ab_gap_level", {28'd0, fifo_level}, 32'd5);
        end
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, 16'(200 + k), 1'b1);
            step();
            if (sum_valid === 1'b1) pulses++;
            chk("ab_head", {16'd0, out_data}, (k < 4) ? 32'(k + 2) : 32'(196 + k));
            chk("ab_level", {28'd0, fifo_level}, 32'd5);
        end
        chk("ab_pulses", pulses, 32'd1);
        chk("ab_frame_sum", {12'd0, frame_sum}, 32'd3320);
        chk("ab_frame_err", {31'd0, frame_err}, 32'd0);
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b0, 16'd0, 1'b1);
            chk("ab_drain_data", {16'd0, out_data}, 32'(211 + j));
            chk("ab_drain_last", {31'd0, out_last}, (j == 4) ? 32'd1 : 32'd0);
            step();
        end

        // ---------------- back-to-back frames: 32 beats 0..31 ----------------
        do_reset();
        pulses = 0;
        first_pulse = -1;
        second_pulse = -1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, 16'(i), 1'b1);
            step();
            chk("b2b_data", {16'd0, out_data}, 32'(i));
            chk("b2b_last", {31'd0, out_last}, ((i % 16) == 15) ? 32'd1 : 32'd0);
            if (sum_valid === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
                else second_pulse = i;
                chk("b2b_frame_sum", {12'd0, frame_sum}, (i < 16) ? 32'd120 : 32'd376);
                chk("b2b_frame_err", {31'd0, frame_err}, 32'd0);
            end
        end
        chk("b2b_pulses", pulses, 32'd2);
        chk("b2b_pulse_gap", second_pulse - first_pulse, 32'd16);
        drive(1'b1, 1'b0, 16'd0, 1'b1);
        step();
        chk("b2b_pulse_end", {31'd0, sum_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
